// File: rtl/scalable_mac_engine_pkg.sv
// Shared encodings and helpers for the precision-scalable MAC engine:
// operand modes, FSM states and the per-mode accumulator field width.
package scalable_mac_engine_pkg;

  typedef enum logic [1:0] {
    MODE_2B  = 2'b00,
    MODE_4B  = 2'b01,
    MODE_8B  = 2'b10,
    MODE_RSV = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // DRAIN waits for the operand and product stages to empty into the accumulator
  localparam int DRAIN_LAST = 2;

  function automatic int field_width(input int k, input int guard);
    return 2 * k + guard;
  endfunction

endpackage

// File: rtl/scalable_mac_engine_psmul_lane.sv
// One lane of the precision-scalable multiplier: splits act/wgt bytes into
// k-bit elements and emits every pairwise product, extended and packed by field.
module psmul_lane
  import scalable_mac_engine_pkg::*;
#(
  parameter int GUARD = 4,
  parameter int WL    = 16 * (4 + GUARD)
) (
  input  logic [7:0]    act,
  input  logic [7:0]    wgt,
  input  logic [1:0]    mode,
  input  logic [1:0]    sign,
  output logic [WL-1:0] prod
);

  for (genvar m = 0; m < 3; m++) begin : g_mode
    localparam int K  = 2 << m;
    localparam int E  = 8 / K;
    localparam int FW = field_width(K, GUARD);

    logic [WL-1:0] pm;
    logic [K-1:0]  ai;
    logic [K-1:0]  wj;
    int            sa;
    int            sw;
    int            pr;

    // Products computed exactly in 32 bits; truncating to FW yields the
    // sign-extended form whenever either operand is signed, else zero-extended.
    always_comb begin
      pm = '0;
      ai = '0;
      wj = '0;
      sa = 0;
      sw = 0;
      pr = 0;
      for (int i = 0; i < E; i++) begin
        for (int j = 0; j < E; j++) begin
          ai = act[K*i +: K];
          wj = wgt[K*j +: K];
          sa = sign[0] ? int'(signed'(ai)) : int'(ai);
          sw = sign[1] ? int'(signed'(wj)) : int'(wj);
          pr = sa * sw;
          pm[(E*i+j)*FW +: FW] = FW'(pr);
        end
      end
    end
  end

  assign prod = (mode == MODE_2B) ? g_mode[0].pm :
                (mode == MODE_4B) ? g_mode[1].pm : g_mode[2].pm;

endmodule

// File: rtl/scalable_mac_engine.sv
// Multi-lane precision-scalable MAC engine (2b/4b/8b) with batch control FSM.
// Define MAC_SATURATE_EN for per-field saturation with sticky out_sat; default wraps.
module scalable_mac_engine
  import scalable_mac_engine_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int GUARD  = 4,
  parameter int BLEN_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0]                    mode,
  input  logic [1:0]                    sign,
  input  logic [BLEN_W-1:0]             batch_len,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [8*LANES-1:0]            act,
  input  logic [8*LANES-1:0]            wgt,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*16*(4+GUARD)-1:0] out_data,
  output logic                          out_sat
);

  localparam int WL = 16 * (4 + GUARD);

  state_t                   state;
  mode_t                    mode_q;
  logic [1:0]               sign_q;
  logic [BLEN_W-1:0]        blen_q;
  logic [BLEN_W-1:0]        beat_cnt;
  logic [BLEN_W-1:0]        beat_nxt;
  logic [1:0]               drain_cnt;
  logic [8*LANES-1:0]       act_q;
  logic [8*LANES-1:0]       wgt_q;
  logic                     op_valid;
  logic                     prod_valid;
  logic [LANES-1:0][WL-1:0] prod_c;
  logic [LANES-1:0][WL-1:0] prod_q;
  logic [LANES-1:0][WL-1:0] acc_q;
  logic [LANES-1:0][WL-1:0] acc_nxt;
  logic                     accept;

  assign accept   = in_valid && in_ready;
  assign beat_nxt = beat_cnt + 1'b1;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    psmul_lane #(.GUARD(GUARD), .WL(WL)) u_mul (
      .act  (act_q[8*l +: 8]),
      .wgt  (wgt_q[8*l +: 8]),
      .mode (mode_q),
      .sign (sign_q),
      .prod (prod_c[l])
    );

    for (genvar m = 0; m < 3; m++) begin : g_mode
      localparam int K  = 2 << m;
      localparam int NF = (8 / K) * (8 / K);
      localparam int FW = field_width(K, GUARD);

      logic [WL-1:0] nxt;
      logic          ovf;
      logic [FW-1:0] fa;
      logic [FW-1:0] fb;
      logic [FW-1:0] fs;

      // Fields are independent adders; a field is signed if either operand is.
      always_comb begin
        nxt = '0;
        ovf = 1'b0;
        fa  = '0;
        fb  = '0;
        fs  = '0;
        for (int p = 0; p < NF; p++) begin
          fa = acc_q[l][p*FW +: FW];
          fb = prod_q[l][p*FW +: FW];
          fs = fa + fb;
`ifdef MAC_SATURATE_EN
          if (|sign_q) begin
            if ((fa[FW-1] == fb[FW-1]) && (fs[FW-1] != fa[FW-1])) begin
              fs  = fa[FW-1] ? {1'b1, {(FW-1){1'b0}}} : {1'b0, {(FW-1){1'b1}}};
              ovf = 1'b1;
            end
          end else if (fs < fa) begin
            fs  = '1;
            ovf = 1'b1;
          end
`endif
          nxt[p*FW +: FW] = fs;
        end
      end
    end

    assign acc_nxt[l] = (mode_q == MODE_2B) ? g_mode[0].nxt :
                        (mode_q == MODE_4B) ? g_mode[1].nxt : g_mode[2].nxt;
  end

`ifdef MAC_SATURATE_EN
  logic [LANES-1:0] lane_ovf;
  logic             sat_run;

  for (genvar l = 0; l < LANES; l++) begin : g_ovf
    assign lane_ovf[l] = (mode_q == MODE_2B) ? g_lane[l].g_mode[0].ovf :
                         (mode_q == MODE_4B) ? g_lane[l].g_mode[1].ovf :
                                               g_lane[l].g_mode[2].ovf;
  end

  // Sticky flag gathered while accumulating, published together with out_data
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_run <= 1'b0;
      out_sat <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      sat_run <= 1'b0;
      out_sat <= 1'b0;
    end else begin
      if (prod_valid && |lane_ovf) sat_run <= 1'b1;
      if (state == ST_DRAIN && drain_cnt == 2'(DRAIN_LAST)) out_sat <= sat_run;
    end
  end
`else
  assign out_sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_2B;
      sign_q     <= '0;
      blen_q     <= '0;
      beat_cnt   <= '0;
      drain_cnt  <= '0;
      act_q      <= '0;
      wgt_q      <= '0;
      op_valid   <= 1'b0;
      prod_valid <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      op_valid   <= accept;
      prod_valid <= op_valid;
      if (accept) begin
        act_q <= act;
        wgt_q <= wgt;
      end
      if (op_valid) prod_q <= prod_c;
      if (prod_valid) acc_q <= acc_nxt;

      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q   <= mode_t'(mode);
            sign_q   <= sign;
            blen_q   <= batch_len;
            beat_cnt <= '0;
            acc_q    <= '0;
            if (batch_len == '0) begin
              out_data  <= '0;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            beat_cnt <= beat_nxt;
            if (beat_nxt == blen_q) begin
              in_ready  <= 1'b0;
              drain_cnt <= '0;
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == 2'(DRAIN_LAST)) begin
            out_data  <= acc_q;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          in_ready <= 1'b0;
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scalable_mac_engine.sv
// Directed testbench for scalable_mac_engine (LANES=4, GUARD=4); overflow
// expectations follow MAC_SATURATE_EN when the bench is built with it.
module tb_scalable_mac_engine;

  localparam int LANES  = 4;
  localparam int GUARD  = 4;
  localparam int BLEN_W = 8;
  localparam int WL     = 16 * (4 + GUARD);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [1:0]            mode = '0;
  logic [1:0]            sign = '0;
  logic [BLEN_W-1:0]     batch_len = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [8*LANES-1:0]    act = '0;
  logic [8*LANES-1:0]    wgt = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [LANES*WL-1:0]   out_data;
  logic                  out_sat;

  int checks = 0;
  int errors = 0;

  scalable_mac_engine #(.LANES(LANES), .GUARD(GUARD), .BLEN_W(BLEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .sign      (sign),
    .batch_len (batch_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .act       (act),
    .wgt       (wgt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch(input logic [1:0] m, input logic [1:0] s, input logic [7:0] len);
    start     = 1'b1;
    mode      = m;
    sign      = s;
    batch_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beats(input logic [31:0] a, input logic [31:0] w, input int n);
    in_valid = 1'b1;
    act      = a;
    wgt      = w;
    for (int i = 0; i < n; i++) tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = -1;
    for (int c = 1; c <= 64; c++) begin
      tick();
      if (out_valid === 1'b1) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got %b expected 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++;
    if (out_sat !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_sat got %b expected 0", out_sat); end
    checks++;
    if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data got %h expected 0", out_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_8b_signed();
    int cyc;
    logic [LANES*WL-1:0] exp_data;
    exp_data = {LANES{128'hFFFE2}};
    start_batch(2'b10, 2'b11, 8'd3);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL 8b_in_ready got %b expected 1", in_ready); end
    send_beats({LANES{8'hFE}}, {LANES{8'h05}}, 3);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL 8b_in_ready_drain got %b expected 0", in_ready); end
    wait_out(cyc);
    checks++;
    if (cyc !== 3) begin errors++; $display("[TB] FAIL 8b_latency got %0d expected 3", cyc); end
    checks++;
    if (out_data !== exp_data) begin errors++; $display("[TB] FAIL 8b_data got %h expected %h", out_data, exp_data); end
    checks++;
    if (out_sat !== 1'b0) begin errors++; $display("[TB] FAIL 8b_sat got %b expected 0", out_sat); end
    take_out();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL 8b_out_valid_drop got %b expected 0", out_valid); end
  endtask

  task automatic test_4b_unsigned();
    int cyc;
    logic [LANES*WL-1:0] exp_data;
    exp_data = {LANES{128'h008006004003}};
    start_batch(2'b01, 2'b00, 8'd1);
    mode      = 2'b10;
    sign      = 2'b11;
    batch_len = 8'd9;
    send_beats({LANES{8'h21}}, {LANES{8'h43}}, 1);
    wait_out(cyc);
    checks++;
    if (cyc !== 3) begin errors++; $display("[TB] FAIL 4b_latency got %0d expected 3", cyc); end
    checks++;
    if (out_data !== exp_data) begin errors++; $display("[TB] FAIL 4b_data got %h expected %h", out_data, exp_data); end
    take_out();
  endtask

  task automatic test_2b_signed();
    int cyc;
    logic [LANES*WL-1:0] exp_data;
    exp_data = {LANES{{16{8'hFE}}}};
    start_batch(2'b00, 2'b11, 8'd2);
    send_beats({LANES{8'hFF}}, {LANES{8'h55}}, 2);
    wait_out(cyc);
    checks++;
    if (cyc !== 3) begin errors++; $display("[TB] FAIL 2b_latency got %0d expected 3", cyc); end
    checks++;
    if (out_data !== exp_data) begin errors++; $display("[TB] FAIL 2b_data got %h expected %h", out_data, exp_data); end
    take_out();
  endtask

  task automatic test_zero_batch();
    start_batch(2'b10, 2'b00, 8'd0);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL zero_out_valid got %b expected 1", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("[TB] FAIL zero_data got %h expected 0", out_data); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL zero_in_ready got %b expected 0", in_ready); end
    take_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_after_take got valid=%b ready=%b expected 0 0", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back_hold();
    int cyc;
    int bad;
    logic [LANES*WL-1:0] exp_data;
    exp_data = {LANES{128'd42}};
    start_batch(2'b10, 2'b00, 8'd2);
    send_beats({LANES{8'h03}}, {LANES{8'h07}}, 2);
    wait_out(cyc);
    checks++;
    if (cyc !== 3) begin errors++; $display("[TB] FAIL hold_latency got %0d expected 3", cyc); end
    bad      = 0;
    start    = 1'b1;
    mode     = 2'b00;
    in_valid = 1'b1;
    act      = {LANES{8'h7F}};
    wgt      = {LANES{8'h7F}};
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== exp_data || in_ready !== 1'b0) bad++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL hold_stable got %0d bad cycles expected 0", bad); end
    checks++;
    if (out_data !== exp_data) begin errors++; $display("[TB] FAIL hold_data got %h expected %h", out_data, exp_data); end
    take_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_release got valid=%b ready=%b expected 0 0", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_batch();
    int seen;
    start_batch(2'b10, 2'b01, 8'd5);
    send_beats({LANES{8'h11}}, {LANES{8'h02}}, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_in_ready got %b expected 0", in_ready); end
    checks++;
    if (out_data !== '0) begin errors++; $display("[TB] FAIL rstmid_data got %h expected 0", out_data); end
    seen     = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b0) seen++;
    end
    in_valid = 1'b0;
    checks++;
    if (seen !== 0) begin errors++; $display("[TB] FAIL rstmid_no_output got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_overflow();
    int cyc;
    logic [LANES*WL-1:0] exp_data;
    logic                exp_sat;
`ifdef MAC_SATURATE_EN
    exp_data = {LANES{128'h7FFFF}};
    exp_sat  = 1'b1;
`else
    exp_data = '0;
    exp_sat  = 1'b0;
`endif
    start_batch(2'b10, 2'b11, 8'd64);
    send_beats({LANES{8'h80}}, {LANES{8'h80}}, 64);
    wait_out(cyc);
    checks++;
    if (cyc !== 3) begin errors++; $display("[TB] FAIL ovf_latency got %0d expected 3", cyc); end
    checks++;
    if (out_data !== exp_data) begin errors++; $display("[TB] FAIL ovf_data got %h expected %h", out_data, exp_data); end
    checks++;
    if (out_sat !== exp_sat) begin errors++; $display("[TB] FAIL ovf_sat got %b expected %b", out_sat, exp_sat); end
    take_out();
  endtask

  initial begin
    $display("[TB] scalable_mac_engine bench start");
    test_reset();
    test_8b_signed();
    test_4b_unsigned();
    test_2b_signed();
    test_zero_batch();
    test_back_to_back_hold();
    test_reset_mid_batch();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
